psum_collector: RTL

Receive end of the systolic array's partial-sum stream. Sits below the bottom PE row of the MMU and takes each column's `psum_o`/`psum_en_o` pair, which arrive skewed by one cycle per column. It deskews the columns into full output rows, buffers the rows in a small FIFO, and presents them on a valid/ready port to the output buffer or accumulator. Malformed rows are flagged, and the block never stalls the array.

---
 rtl/mmu_pkg.sv | 11 +
 rtl/psum_collector_if.sv | 23 ++
 rtl/psum_row_fifo.sv | 42 ++++
 rtl/psum_collector.sv | 79 +++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU widths and row packing helpers
package mmu_pkg;
    localparam int PSUM_WIDTH = 32;
    localparam int COLS = 4;
    localparam int ROW_WIDTH = COLS * PSUM_WIDTH;
    typedef logic [PSUM_WIDTH-1:0] psum_t;
    typedef logic [ROW_WIDTH-1:0] row_t;
    function automatic psum_t get_col(row_t r, int c);
        return r[c*PSUM_WIDTH +: PSUM_WIDTH];
    endfunction
endpackage

// File: rtl/psum_collector_if.sv
// psum_collector_if: skewed psum stream in, deskewed row stream and flags out
interface psum_collector_if #(
    parameter int COLS = mmu_pkg::COLS,
    parameter int PSUM_WIDTH = mmu_pkg::PSUM_WIDTH
);
    logic [COLS*PSUM_WIDTH-1:0] psum_i;
    logic [COLS-1:0] psum_en_i;
    logic clear_i;
    logic [COLS*PSUM_WIDTH-1:0] out_data_o;
    logic out_valid_o;
    logic out_ready_i;
    logic overflow_o;
    logic skew_err_o;
    logic busy_o;
    modport slave (
        input psum_i, psum_en_i, clear_i, out_ready_i,
        output out_data_o, out_valid_o, overflow_o, skew_err_o, busy_o
    );
    modport master (
        output psum_i, psum_en_i, clear_i, out_ready_i,
        input out_data_o, out_valid_o, overflow_o, skew_err_o, busy_o
    );
endinterface

// File: rtl/psum_row_fifo.sv
// psum_row_fifo: synchronous row FIFO; a push while full is taken only if a pop frees a slot that cycle
module psum_row_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0] r_count;
    logic w_push;
    logic w_pop;
    assign o_full = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_head = r_mem[r_rd];
    assign w_pop = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem <= '0;
            r_wr <= '0;
            r_rd <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/psum_collector.sv
// psum_collector: deskews per-column psums into rows, buffers them, flags drops and partial rows
module psum_collector #(
    parameter int COLS = mmu_pkg::COLS,
    parameter int PSUM_WIDTH = mmu_pkg::PSUM_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    psum_collector_if.slave s_bus
);
    logic [COLS-1:0] w_en;
    logic [COLS*PSUM_WIDTH-1:0] w_row;
    logic [COLS-1:0] w_busy_col;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_all;
    logic w_mixed;
    logic r_overflow;
    logic r_skew_err;
    // column c is delayed COLS-1-c cycles so the whole row lines up with the last column
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int S = COLS - 1 - c;
        if (S == 0) begin : g_direct
            assign w_en[c] = s_bus.psum_en_i[c];
            assign w_row[c*PSUM_WIDTH +: PSUM_WIDTH] = s_bus.psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
            assign w_busy_col[c] = 1'b0;
        end else begin : g_chain
            logic [S-1:0] r_en;
            logic [S-1:0][PSUM_WIDTH-1:0] r_d;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_en <= '0;
                    r_d <= '0;
                end else begin
                    r_en[0] <= s_bus.psum_en_i[c];
                    r_d[0] <= s_bus.psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
                    for (int s = 1; s < S; s++) begin
                        r_en[s] <= r_en[s-1];
                        r_d[s] <= r_d[s-1];
                    end
                end
            end
            assign w_en[c] = r_en[S-1];
            assign w_row[c*PSUM_WIDTH +: PSUM_WIDTH] = r_d[S-1];
            assign w_busy_col[c] = |r_en;
        end
    end
    assign w_all = &w_en;
    assign w_mixed = |w_en & ~w_all;
    assign w_pop = ~w_empty & s_bus.out_ready_i;
    psum_row_fifo #(
        .WIDTH(COLS*PSUM_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .i_push(w_all),
        .i_pop(w_pop),
        .i_data(w_row),
        .o_full(w_full),
        .o_empty(w_empty),
        .o_head(s_bus.out_data_o)
    );
    // set beats clear when both land in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            r_overflow <= (w_all & w_full & ~w_pop) | (r_overflow & ~s_bus.clear_i);
            r_skew_err <= w_mixed | (r_skew_err & ~s_bus.clear_i);
        end
    end
    assign s_bus.out_valid_o = ~w_empty;
    assign s_bus.overflow_o = r_overflow;
    assign s_bus.skew_err_o = r_skew_err;
    assign s_bus.busy_o = |w_busy_col | ~w_empty;
endmodule
